// File: rtl/ladybird_csr_access_pkg.sv
// ============================================================================
// Packages   : ladybird_config, ladybird_riscv_helper
// Description: Shared configuration (data width) and RISC-V SYSTEM/CSR
//              helper definitions used by the CSR access unit.
//              ladybird_config       - XLEN
//              ladybird_riscv_helper - CSR funct3 codes, privilege modes,
//                                      illegal-instruction cause, FSM states
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package ladybird_config;
    localparam int XLEN = 32;
endpackage : ladybird_config

package ladybird_riscv_helper;
    // funct3 encodings of the Zicsr instructions (000 and 100 are not CSR ops)
    localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
    localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
    localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
    localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
    localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
    localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

    localparam logic [1:0] PRIV_MODE_U = 2'd0;
    localparam logic [1:0] PRIV_MODE_S = 2'd1;
    localparam logic [1:0] PRIV_MODE_M = 2'd3;

    localparam logic [4:0] EXC_ILLEGAL_INST = 5'd2;

    typedef enum logic [1:0] {
        CSR_IDLE   = 2'd0,
        CSR_ACCESS = 2'd1,
        CSR_RESP   = 2'd2
    } csr_access_state_t;
endpackage : ladybird_riscv_helper

`default_nettype wire

// File: rtl/ladybird_csr_access.sv
// ============================================================================
// Module     : ladybird_csr_access
// Description: Executes one Zicsr SYSTEM instruction per transaction.
//              IDLE accepts a request, ACCESS performs the single-cycle CSR
//              file access and captures the result, RESP holds the
//              writeback/trap response until the commit stage takes it.
// Ports      : clk, rst (async, active-high)
//              mode                    - current privilege level
//              req_valid/req_ready     - request handshake
//              req_inst/req_pc/req_rs1 - instruction, its PC, rs1 value
//              csr_op/csr_valid/csr_addr/csr_data/csr_rdata - CSR file port
//              rsp_valid/rsp_ready     - response handshake
//              rsp_rd/rsp_we/rsp_data/rsp_pc/rsp_exception_code - result
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module ladybird_csr_access
    import ladybird_riscv_helper::*;
#(
    parameter int XLEN = ladybird_config::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_inst,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_rs1,
    output logic [2:0]      csr_op,
    output logic            csr_valid,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_data,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_rd,
    output logic            rsp_we,
    output logic [XLEN-1:0] rsp_data,
    output logic [XLEN-1:0] rsp_pc,
    output logic [4:0]      rsp_exception_code
);

    csr_access_state_t r_state;
    csr_access_state_t w_next_state;

    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;

    logic [4:0]      r_rsp_rd;
    logic            r_rsp_we;
    logic [XLEN-1:0] r_rsp_data;
    logic [4:0]      r_rsp_exc;

    logic [2:0]      w_funct3;
    logic [4:0]      w_field;      // rs1 index or uimm, depending on funct3[2]
    logic [11:0]     w_addr;
    logic            w_write_eff;
    logic            w_bad_op;
    logic            w_illegal;

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    always_comb begin
        w_funct3 = r_inst[14:12];
        w_field  = r_inst[19:15];
        w_addr   = r_inst[31:20];

        // Swaps always write; set/clear only write with a non-zero mask source
        w_write_eff = (w_field != 5'd0);
        w_bad_op    = 1'b0;
        case (w_funct3)
            FUNCT3_CSRRW, FUNCT3_CSRRWI: w_write_eff = 1'b1;
            FUNCT3_CSRRS, FUNCT3_CSRRC,
            FUNCT3_CSRRSI, FUNCT3_CSRRCI: w_bad_op = 1'b0;
            default:                      w_bad_op = 1'b1;
        endcase

        // addr[9:8] is the lowest privilege allowed; addr[11:10]==11 is read-only
        w_illegal = w_bad_op
                  || (w_addr[9:8] > mode)
                  || ((w_addr[11:10] == 2'b11) && w_write_eff);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CSR_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake / CSR port outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        csr_valid    = 1'b0;
        csr_op       = 3'd0;
        csr_addr     = 12'd0;
        csr_data     = '0;

        case (r_state)
            CSR_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = CSR_ACCESS;
                end
            end
            CSR_ACCESS: begin
                csr_op    = w_funct3;
                csr_addr  = w_addr;
                csr_data  = w_funct3[2] ? XLEN'(w_field) : r_rs1;
                csr_valid = w_write_eff && !w_illegal;
                w_next_state = CSR_RESP;
            end
            CSR_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = CSR_IDLE;
                end
            end
            default: begin
                w_next_state = CSR_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst     <= 32'd0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rsp_rd   <= 5'd0;
            r_rsp_we   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_exc  <= 5'd0;
        end else begin
            if ((r_state == CSR_IDLE) && req_valid) begin
                r_inst <= req_inst;
                r_pc   <= req_pc;
                r_rs1  <= req_rs1;
            end
            if (r_state == CSR_ACCESS) begin
                r_rsp_rd <= r_inst[11:7];
                if (w_illegal) begin
                    // The trap value carries the faulting instruction word
                    r_rsp_data <= XLEN'(r_inst);
                    r_rsp_we   <= 1'b0;
                    r_rsp_exc  <= EXC_ILLEGAL_INST;
                end else begin
                    r_rsp_data <= csr_rdata;
                    r_rsp_we   <= (r_inst[11:7] != 5'd0);
                    r_rsp_exc  <= 5'd0;
                end
            end
        end
    end

    assign rsp_rd             = r_rsp_rd;
    assign rsp_we             = r_rsp_we;
    assign rsp_data           = r_rsp_data;
    assign rsp_pc             = r_pc;
    assign rsp_exception_code = r_rsp_exc;

endmodule : ladybird_csr_access

`default_nettype wire

// File: tb/tb_ladybird_csr_access.sv
// ============================================================================
// Module     : tb_ladybird_csr_access
// Description: Self-checking bench for ladybird_csr_access. Directed cases
//              for the documented scenarios, randomized CSR instructions
//              checked against a rule-level reference model, response hold
//              and asynchronous reset behaviour.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ladybird_csr_access;
    import ladybird_riscv_helper::*;

    localparam int XLEN = ladybird_config::XLEN;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mode;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_inst;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_rs1;
    logic [2:0]      csr_op;
    logic            csr_valid;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
    logic [XLEN-1:0] csr_rdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [4:0]      rsp_rd;
    logic            rsp_we;
    logic [XLEN-1:0] rsp_data;
    logic [XLEN-1:0] rsp_pc;
    logic [4:0]      rsp_exception_code;

    // CSR file stand-in: read data depends on the address presented
    logic [XLEN-1:0] rdata_pat;
    assign csr_rdata = rdata_pat ^ XLEN'(csr_addr);

    always #5 clk = ~clk;

    ladybird_csr_access #(.XLEN(XLEN)) dut (
        .clk                (clk),
        .rst                (rst),
        .mode               (mode),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_inst           (req_inst),
        .req_pc             (req_pc),
        .req_rs1            (req_rs1),
        .csr_op             (csr_op),
        .csr_valid          (csr_valid),
        .csr_addr           (csr_addr),
        .csr_data           (csr_data),
        .csr_rdata          (csr_rdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rd             (rsp_rd),
        .rsp_we             (rsp_we),
        .rsp_data           (rsp_data),
        .rsp_pc             (rsp_pc),
        .rsp_exception_code (rsp_exception_code)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] src, input logic [11:0] addr);
        return {addr, src, f3, rd, 7'b1110011};
    endfunction

    // Expected response of the current transaction
    logic [4:0]      e_rd;
    logic            e_we;
    logic [XLEN-1:0] e_data;
    logic [XLEN-1:0] e_pc;
    logic [4:0]      e_exc;

    task automatic check_rsp(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
        chk({tag, "_rsp_rd"},    64'(rsp_rd), 64'(e_rd));
        chk({tag, "_rsp_we"},    64'(rsp_we), 64'(e_we));
        chk({tag, "_rsp_data"},  64'(rsp_data), 64'(e_data));
        chk({tag, "_rsp_pc"},    64'(rsp_pc), 64'(e_pc));
        chk({tag, "_rsp_exc"},   64'(rsp_exception_code), 64'(e_exc));
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_csr_valid"}, 64'(csr_valid), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        chk({tag, "_csr_valid"}, 64'(csr_valid), 64'(0));
        chk({tag, "_csr_bus"},   64'({csr_op, csr_addr}), 64'(0));
        chk({tag, "_csr_data"},  64'(csr_data), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_meta"},  64'({rsp_rd, rsp_we, rsp_exception_code}), 64'(0));
        chk({tag, "_rsp_data"},  64'(rsp_data), 64'(0));
        chk({tag, "_rsp_pc"},    64'(rsp_pc), 64'(0));
    endtask

    // One full transaction. Entered and left at posedge+1 with the DUT idle.
    task automatic run_txn(input string tag, input logic [31:0] inst,
                           input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] pc,
                           input logic [1:0] m, input logic [XLEN-1:0] rdval,
                           input int hold);
        logic [2:0]  f3;
        logic [4:0]  src;
        logic [11:0] addr;
        logic        is_csr_op, writes, illegal;

        // Reference rules, stated by instruction meaning
        f3   = inst[14:12];
        src  = inst[19:15];
        addr = inst[31:20];
        is_csr_op = (f3 != 3'b000) && (f3 != 3'b100);
        if (f3 == FUNCT3_CSRRW || f3 == FUNCT3_CSRRWI) writes = 1'b1;
        else                                           writes = (src != 5'd0);
        illegal = !is_csr_op || (int'(addr[9:8]) > int'(m))
                  || ((addr[11:10] == 2'b11) && writes);
        e_rd   = inst[11:7];
        e_pc   = pc;
        e_we   = !illegal && (inst[11:7] != 5'd0);
        e_data = illegal ? XLEN'(inst) : rdval;
        e_exc  = illegal ? EXC_ILLEGAL_INST : 5'd0;

        // Request cycle; mode here is a decoy since only ACCESS samples it
        req_inst  = inst;
        req_pc    = pc;
        req_rs1   = rs1;
        req_valid = 1'b1;
        mode      = 2'($urandom);
        rdata_pat = rdval ^ XLEN'(addr);
        chk({tag, "_idle_ready"}, 64'(req_ready), 64'(1));
        @(posedge clk); #1;

        // ACCESS cycle; new request contents must be ignored
        mode      = m;
        req_valid = 1'($urandom);
        req_inst  = $urandom;
        req_rs1   = XLEN'($urandom);
        req_pc    = XLEN'($urandom);
        #1;
        chk({tag, "_csr_valid"}, 64'(csr_valid), 64'(writes && !illegal));
        chk({tag, "_csr_op"},    64'(csr_op), 64'(f3));
        chk({tag, "_csr_addr"},  64'(csr_addr), 64'(addr));
        chk({tag, "_csr_data"},  64'(csr_data), f3[2] ? 64'(src) : 64'(rs1));
        chk({tag, "_acc_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_acc_rspv"},  64'(rsp_valid), 64'(0));
        @(posedge clk); #1;

        // RESP: scramble mode/read data to prove the response was captured
        mode      = 2'($urandom);
        rdata_pat = XLEN'($urandom);
        check_rsp(tag);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom);
            req_inst  = $urandom;
            check_rsp({tag, "_hold"});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, "_done_rspv"},  64'(rsp_valid), 64'(0));
        chk({tag, "_done_ready"}, 64'(req_ready), 64'(1));
    endtask

    // Global time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'hC00, 12'h100, 12'h7C0, 12'hF14};
        logic [1:0]  modes [4] = '{PRIV_MODE_U, PRIV_MODE_S, PRIV_MODE_M, 2'd2};
        logic [11:0] a;
        logic [4:0]  s;

        rst = 1'b1; mode = PRIV_MODE_M; req_valid = 1'b0; req_inst = '0;
        req_pc = '0; req_rs1 = '0; rsp_ready = 1'b0; rdata_pat = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        // Documented scenarios
        run_txn("csrrw_mstatus", enc(FUNCT3_CSRRW, 5'd5, 5'd10, 12'h305), 32'h8000_0100,
                32'h0000_1000, PRIV_MODE_M, 32'h0, 0);
        run_txn("csrrs_cycle", enc(FUNCT3_CSRRS, 5'd6, 5'd0, 12'hC00), 32'hDEAD_BEEF,
                32'h0000_1004, PRIV_MODE_M, 32'h1234, 1);
        run_txn("csrrw_ro", enc(FUNCT3_CSRRW, 5'd0, 5'd3, 12'hC00), 32'h1,
                32'h0000_1008, PRIV_MODE_M, 32'h5555, 0);
        run_txn("priv_u", enc(FUNCT3_CSRRS, 5'd1, 5'd0, 12'h300), 32'h0,
                32'h0000_100C, PRIV_MODE_U, 32'h77, 0);
        run_txn("priv_m", enc(FUNCT3_CSRRS, 5'd1, 5'd0, 12'h300), 32'h0,
                32'h0000_1010, PRIV_MODE_M, 32'h77, 0);
        run_txn("csrrsi", enc(FUNCT3_CSRRSI, 5'd7, 5'd8, 12'h300), 32'hFFFF_FFFF,
                32'h0000_1014, PRIV_MODE_M, 32'hA5A5, 0);
        run_txn("csrrci0", enc(FUNCT3_CSRRCI, 5'd7, 5'd0, 12'h300), 32'hFFFF_FFFF,
                32'h0000_1018, PRIV_MODE_M, 32'h5A5A, 0);
        run_txn("funct3_0", enc(3'b000, 5'd4, 5'd1, 12'h300), 32'h9,
                32'h0000_101C, PRIV_MODE_M, 32'h1, 0);
        run_txn("hold5", enc(FUNCT3_CSRRC, 5'd9, 5'd2, 12'h100), 32'h0F0F_0F0F,
                32'h0000_1020, PRIV_MODE_S, 32'hCAFE_F00D, 5);

        // Randomized CSR instructions
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 5)];
            s = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_txn("rand", enc(3'($urandom), 5'($urandom), s, a), XLEN'($urandom),
                    XLEN'($urandom), modes[$urandom_range(0, 3)], XLEN'($urandom),
                    $urandom_range(0, 3));
        end

        // Reset while a response is being held: dropped immediately, never returns
        req_inst = enc(FUNCT3_CSRRW, 5'd5, 5'd1, 12'h305); req_pc = 32'h2000;
        req_rs1 = 32'h1; mode = PRIV_MODE_M; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_pre_rspv", 64'(rsp_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_hold");
        #3 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rst_hold_no_rsp", 64'(rsp_valid), 64'(0));
        end

        // Reset during ACCESS: csr_valid drops at once
        req_inst = enc(FUNCT3_CSRRW, 5'd5, 5'd1, 12'h305); req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_acc_pre_csrv", 64'(csr_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_acc_csrv", 64'(csr_valid), 64'(0));
        #2 rst = 1'b0;

        // First request after release is accepted on the next edge
        @(posedge clk); #1;
        run_txn("after_rst", enc(FUNCT3_CSRRWI, 5'd3, 5'd17, 12'h305), 32'h0,
                32'h0000_3000, PRIV_MODE_M, 32'h4242, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ladybird_csr_access

`default_nettype wire
